// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Moore control FSM that steps the lab datapath through the
//               instruction fetch sequence (MAR<-PC, PC<-PC+1, MDR<-M[MAR],
//               IR<-MDR), then waits for an operator Continue press/release
//               before the next fetch. Also counts completed fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int MEM_WAIT = 2,   // memory-read cycles, 1..15
    parameter int CNT_W    = 16   // completed-fetch counter width
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Continue,
    output logic             GATEPC,
    output logic             GATEMDR,
    output logic             LD_MAR,
    output logic             LD_MDR,
    output logic             LD_IR,
    output logic             LD_PC,
    output logic             PCMUX_EN,
    output logic             MIO_EN,
    output logic             Mem_OE,
    output logic             Busy,
    output logic [CNT_W-1:0] Fetch_Count
);

    typedef enum logic [2:0] {
        ST_HALTED    = 3'd0,
        ST_MAR       = 3'd1,
        ST_READ      = 3'd2,
        ST_IR        = 3'd3,
        ST_PAUSE     = 3'd4,
        ST_PAUSE_REL = 3'd5
    } state_t;

    // Wait-counter value on the final memory-read cycle.
    localparam logic [3:0] c_read_last = 4'(MEM_WAIT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_wait;
    logic [CNT_W-1:0] r_fetch_count;
    logic             w_read_last;

    assign w_read_last = (r_state == ST_READ) && (r_wait == c_read_last);
    assign Fetch_Count = r_fetch_count;

    // State register; reset overrides every state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_HALTED;
        end else begin
            r_state <= w_next;
        end
    end

    // Memory wait counter: zeroed when entering the read, steps until the last read cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wait <= 4'd0;
        end else if (r_state == ST_MAR) begin
            r_wait <= 4'd0;
        end else if ((r_state == ST_READ) && !w_read_last) begin
            r_wait <= r_wait + 4'd1;
        end
    end

    // Completed-fetch counter, bumped on the edge leaving the IR load; wraps naturally.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fetch_count <= '0;
        end else if (r_state == ST_IR) begin
            r_fetch_count <= r_fetch_count + CNT_W'(1);
        end
    end

    // Next-state and Moore output decode from the current state.
    always_comb begin
        w_next   = r_state;
        GATEPC   = 1'b0;
        GATEMDR  = 1'b0;
        LD_MAR   = 1'b0;
        LD_MDR   = 1'b0;
        LD_IR    = 1'b0;
        LD_PC    = 1'b0;
        PCMUX_EN = 1'b0;
        MIO_EN   = 1'b0;
        Mem_OE   = 1'b0;
        Busy     = 1'b0;
        case (r_state)
            ST_HALTED: begin
                if (Run) begin
                    w_next = ST_MAR;
                end
            end
            ST_MAR: begin
                GATEPC   = 1'b1;
                LD_MAR   = 1'b1;
                LD_PC    = 1'b1;
                PCMUX_EN = 1'b1;
                Busy     = 1'b1;
                w_next   = ST_READ;
            end
            ST_READ: begin
                MIO_EN = 1'b1;
                Mem_OE = 1'b1;
                Busy   = 1'b1;
                if (w_read_last) begin
                    LD_MDR = 1'b1;
                    w_next = ST_IR;
                end
            end
            ST_IR: begin
                GATEMDR = 1'b1;
                LD_IR   = 1'b1;
                Busy    = 1'b1;
                w_next  = ST_PAUSE;
            end
            ST_PAUSE: begin
                Busy = 1'b1;
                if (Continue) begin
                    w_next = ST_PAUSE_REL;
                end
            end
            ST_PAUSE_REL: begin
                Busy = 1'b1;
                if (!Continue) begin
                    w_next = ST_MAR;
                end
            end
            default: begin
                // Unused encodings recover to a safe idle.
                w_next = ST_HALTED;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer. Two instances:
//               MEM_WAIT=2/CNT_W=16 and MEM_WAIT=1/CNT_W=4. Expected per-cycle
//               outputs are queued as stimulus is driven and compared by a
//               monitor on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    // Control vector order: GATEPC GATEMDR LD_MAR LD_MDR LD_IR LD_PC PCMUX_EN MIO_EN Mem_OE
    localparam logic [8:0] c_idle = 9'b000000000;
    localparam logic [8:0] c_mar  = 9'b101001100;
    localparam logic [8:0] c_rd   = 9'b000000011;
    localparam logic [8:0] c_rdl  = 9'b000100011;
    localparam logic [8:0] c_ir   = 9'b010010000;

    typedef struct packed {
        logic [8:0]  ctl;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0 = 1'b1, run0 = 1'b0, cont0 = 1'b0;
    logic        rst1 = 1'b1, run1 = 1'b0, cont1 = 1'b0;
    logic [8:0]  ctl0, ctl1;
    logic        busy0, busy1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.MEM_WAIT(2), .CNT_W(16)) u_dut0 (
        .Clk(clk), .Reset(rst0), .Run(run0), .Continue(cont0),
        .GATEPC(ctl0[8]), .GATEMDR(ctl0[7]), .LD_MAR(ctl0[6]), .LD_MDR(ctl0[5]),
        .LD_IR(ctl0[4]), .LD_PC(ctl0[3]), .PCMUX_EN(ctl0[2]), .MIO_EN(ctl0[1]),
        .Mem_OE(ctl0[0]), .Busy(busy0), .Fetch_Count(cnt0)
    );

    fetch_sequencer #(.MEM_WAIT(1), .CNT_W(4)) u_dut1 (
        .Clk(clk), .Reset(rst1), .Run(run1), .Continue(cont1),
        .GATEPC(ctl1[8]), .GATEMDR(ctl1[7]), .LD_MAR(ctl1[6]), .LD_MDR(ctl1[5]),
        .LD_IR(ctl1[4]), .LD_PC(ctl1[3]), .PCMUX_EN(ctl1[2]), .MIO_EN(ctl1[1]),
        .Mem_OE(ctl1[0]), .Busy(busy1), .Fetch_Count(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle's inputs for an instance and queue the outputs expected in this cycle.
    task automatic drive(input int sel, input logic rst, input logic run, input logic cont,
                         input bit chk, input logic [8:0] ctl, input logic busy, input int cnt);
        exp_t e;
        @(posedge clk);
        #1;
        if (sel == 0) begin
            rst0 = rst; run0 = run; cont0 = cont;
        end else begin
            rst1 = rst; run1 = run; cont1 = cont;
        end
        if (chk) begin
            e.ctl  = ctl;
            e.busy = busy;
            e.cnt  = 16'(cnt);
            if (sel == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
    endtask

    // One fetch from S_MAR through S_IR; the caller has already issued the start edge.
    task automatic fetch_seq(input int sel, input int mw, input int cnt_before);
        drive(sel, 0, 0, 0, 1, c_mar, 1, cnt_before);
        for (int i = 0; i < mw; i++) begin
            drive(sel, 0, 0, 0, 1, (i == mw - 1) ? c_rdl : c_rd, 1, cnt_before);
        end
        drive(sel, 0, 0, 0, 1, c_ir, 1, cnt_before);
    endtask

    // Scoreboard compare for instance 0 plus per-cycle exclusivity checks.
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            exp_t e;
            e = q0.pop_front();
            check("i0_ctl",   32'(ctl0), 32'(e.ctl));
            check("i0_busy",  32'(busy0), 32'(e.busy));
            check("i0_count", 32'(cnt0), 32'(e.cnt));
            check("i0_ld_onehot", 32'($countones({ctl0[6], ctl0[5], ctl0[4]}) <= 1), 32'd1);
            check("i0_gate_excl", 32'(ctl0[8] & ctl0[7]), 32'd0);
        end
    end

    // Scoreboard compare for instance 1 plus per-cycle exclusivity checks.
    always @(negedge clk) begin
        if (q1.size() > 0) begin
            exp_t e;
            e = q1.pop_front();
            check("i1_ctl",   32'(ctl1), 32'(e.ctl));
            check("i1_busy",  32'(busy1), 32'(e.busy));
            check("i1_count", 32'(cnt1), 32'(e.cnt[3:0]));
            check("i1_ld_onehot", 32'($countones({ctl1[6], ctl1[5], ctl1[4]}) <= 1), 32'd1);
            check("i1_gate_excl", 32'(ctl1[8] & ctl1[7]), 32'd0);
        end
    end

    initial begin
        // Reset held two cycles, then idle with Run low.
        drive(0, 1, 0, 0, 1, c_idle, 0, 0);
        drive(0, 1, 0, 0, 1, c_idle, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, c_idle, 0, 0);

        // Single fetch, MEM_WAIT=2.
        drive(0, 0, 1, 0, 1, c_idle, 0, 0);
        fetch_seq(0, 2, 0);

        // Continue held high in PAUSE: no activity, Run ignored.
        for (int i = 0; i < 10; i++) drive(0, 0, (i % 3 == 0), 1, 1, c_idle, 1, 1);
        drive(0, 0, 0, 0, 1, c_idle, 1, 1);
        fetch_seq(0, 2, 1);

        // Second press, then reset during the first read cycle.
        drive(0, 0, 0, 1, 1, c_idle, 1, 2);
        drive(0, 0, 0, 0, 1, c_idle, 1, 2);
        drive(0, 0, 0, 0, 1, c_mar, 1, 2);
        drive(0, 1, 0, 0, 1, c_rd, 1, 2);
        drive(0, 0, 0, 0, 1, c_idle, 0, 0);
        drive(0, 0, 0, 0, 1, c_idle, 0, 0);
        drive(0, 0, 0, 0, 1, c_idle, 0, 0);

        // MEM_WAIT=1, CNT_W=4: single-cycle read and counter wrap over 16 fetches.
        drive(1, 1, 0, 0, 1, c_idle, 0, 0);
        drive(1, 0, 1, 0, 1, c_idle, 0, 0);
        fetch_seq(1, 1, 0);
        for (int k = 1; k < 16; k++) begin
            drive(1, 0, 0, 1, 1, c_idle, 1, k % 16);
            drive(1, 0, 0, 0, 1, c_idle, 1, k % 16);
            fetch_seq(1, 1, k % 16);
        end
        drive(1, 0, 0, 0, 1, c_idle, 1, 0);
        drive(1, 0, 0, 0, 1, c_idle, 1, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drain", 32'(q0.size() + q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
